branch_update_ctrl: RTL and testbench
=====================================

# branch_update_ctrl

Sequences all writes into the branch predictor's 2-bit counter table, which has a single write port. Tracks in-flight branches from DECODE to EXEC in an in-order queue and arbitrates between DECODE allocation resets and EXEC training updates. Maintains the global history register and flushes wrong-path branches on a misprediction. Sits between the decode/exec pipeline stages and the predictor table.

## Interface
- DEPTH, 4: in-flight branch queue entries; a power of 2, at least 2
- IDX_W, 8: predictor table index width
- HIST_W, 4: global history width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_valid  in  1  decode presents a branch this cycle
- d_index  in  IDX_W  table index for that branch
- d_new  in  1  branch was newly allocated; its counter entry must be reset
- d_ready  out  1  push accepted when d_valid && d_ready
- x_valid  in  1  exec resolves the oldest in-flight branch
- x_taken  in  1  actual outcome
- x_mispredict  in  1  prediction was wrong; qualified by x_valid
- tbl_we  out  1  table write strobe
- tbl_op  out  2  01 reset, 10 train, 11 reset-then-train, 00 idle
- tbl_index  out  IDX_W  entry to write
- tbl_taken  out  1  training direction
- history  out  HIST_W  global history
- count  out  $clog2(DEPTH+1)  queue occupancy
- x_err  out  1  one-cycle pulse: x_valid received with an empty queue

## Operation
- **Queue:** circular FIFO of d_index values with rd/wr pointers that wrap modulo DEPTH.
  - Push on d_valid && d_ready.
  - Pop on x_valid && count>0.
- **d_ready:** count<DEPTH && !rst_pend && rst_n.
- **Pending reset:** one register pair, rst_pend/rst_idx.
  - A push with d_new sets rst_pend=1 and rst_idx=d_index.
  - It always loses to a same-cycle train (see arbitration).
  - When rst_pend=1, d_ready=0, so no new allocation can arrive until the reset drains.
- **Arbitration (one table write per cycle):**
  - If a pop occurs, issue a train: tbl_index=popped index, tbl_taken=x_taken, tbl_op=10.
    - If rst_pend && rst_idx==popped index, issue tbl_op=11 instead and clear rst_pend.
  - Otherwise, if rst_pend=1, issue tbl_op=01 with tbl_index=rst_idx and clear rst_pend.
  - Otherwise tbl_we=0, tbl_op=00.
- **Same-cycle d_new push and pop:** the train wins. The new reset is captured into rst_pend and issues the next cycle unless another train arrives. Trains may starve a reset indefinitely; this is accepted.
- **History:** on each pop, history <= {history[HIST_W-2:0], x_taken}. No change on x_err.
- **Mispredict (x_valid && x_mispredict && count>0):**
  - Pop the head as normal and train it.
  - Discard all remaining entries: count <= 0 and rd_ptr <= wr_ptr.
  - Drop any same-cycle push, including its d_new reset request.
  - An existing rst_pend is retained, because that table slot was already reallocated.
- **Empty resolve (x_valid && count==0):**
  - No pop, no train, no history change.
  - x_err pulses for one cycle.
  - A same-cycle push proceeds; there is no bypass.
- **Full queue:** d_ready=0. A same-cycle pop frees the slot for the next cycle only.

## Timing
- **Reset:** every register clears asynchronously on rst_n low.
  - tbl_we=0, tbl_op=00, tbl_index=0, tbl_taken=0, history=0, count=0, x_err=0, rst_pend=0.
  - d_ready=0 while rst_n is low and 1 from the first cycle after release.
- **Reset mid-operation:** all queued entries and the pending reset are lost. No table write is issued.
- **Registered outputs:** tbl_*, history, count and x_err all change the cycle after the causing input edge.
- **Latencies:**
  - Train: x_valid sampled at edge N produces tbl_we=1 during cycle N+1.
  - Reset: uncontended, a d_new push at edge N produces tbl_op=01 during cycle N+2 (capture, then issue).
- **Combinational output:** d_ready is derived from registered state only. It has no combinational path from d_valid or x_valid.
- **Exec timing:** exec resolves a branch no earlier than 2 cycles after its push.

## Test plan
- **Reset then push:** push d_index=0x08 with d_new=1, then 0x10 with d_new=0 -> count=2; tbl_op=01, tbl_index=0x08 one cycle after rst_pend sets; d_ready=0 during that cycle.
- **In-order train:** resolve x_taken=1, then 0 -> trains to 0x08 (tbl_taken=1) then 0x10 (tbl_taken=0); history goes 0000 -> 0001 -> 0010; count=0.
- **Conflict:** push 0x18 with d_new=1 in the same cycle a pop of 0x20 trains.
  - Expect tbl_op=10, index 0x20, then tbl_op=01, index 0x18.
  - Repeat with the popped index equal to rst_idx=0x18 -> single tbl_op=11, rst_pend cleared.
- **Full/wrap:** 4 pushes -> d_ready=0, count=4; a 5th d_valid is ignored; pop plus push 9 times -> pointers wrap and trained indices stay in FIFO order.
- **Mispredict flush:** queue holds 0x01, 0x02, 0x03; x_valid && x_mispredict with a same-cycle push of 0x04 -> trains 0x01, count=0, 0x04 is never trained.
- **Empty resolve and async reset:**
  - x_valid with count=0 -> x_err=1 for one cycle, history unchanged, no tbl_we.
  - Drop rst_n mid-stream -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/branch_update_ctrl.sv
// Sequences all writes into the single-port 2-bit counter table: decode allocation resets
// and exec training updates, with an in-order in-flight queue and global history.
module branch_update_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned HIST_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       d_valid,
    input  logic [IDX_W-1:0]           d_index,
    input  logic                       d_new,
    output logic                       d_ready,
    input  logic                       x_valid,
    input  logic                       x_taken,
    input  logic                       x_mispredict,
    output logic                       tbl_we,
    output logic [1:0]                 tbl_op,
    output logic [IDX_W-1:0]           tbl_index,
    output logic                       tbl_taken,
    output logic [HIST_W-1:0]          history,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       x_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_RST   = 2'b01;
    localparam logic [1:0] OP_TRAIN = 2'b10;
    localparam logic [1:0] OP_BOTH  = 2'b11;

    logic [IDX_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rst_pend_q, rst_pend_d;
    logic [IDX_W-1:0]  rst_idx_q, rst_idx_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic              tbl_we_q, tbl_we_d;
    logic [1:0]        tbl_op_q, tbl_op_d;
    logic [IDX_W-1:0]  tbl_index_q, tbl_index_d;
    logic              tbl_taken_q, tbl_taken_d;
    logic              x_err_q, x_err_d;

    logic              pop;
    logic              flush;
    logic              push;
    logic [IDX_W-1:0]  head;

    // A pending reset blocks new allocations so only one reset is ever outstanding.
    assign d_ready = rst_n && (count_q < CNT_W'(DEPTH)) && !rst_pend_q;

    always_comb begin
        head        = mem_q[rd_ptr_q];
        pop         = x_valid && (count_q != '0);
        flush       = pop && x_mispredict;
        push        = d_valid && d_ready && !flush;

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        rst_pend_d  = rst_pend_q;
        rst_idx_d   = rst_idx_q;
        hist_d      = hist_q;
        tbl_we_d    = 1'b0;
        tbl_op_d    = OP_IDLE;
        tbl_index_d = tbl_index_q;
        tbl_taken_d = tbl_taken_q;
        x_err_d     = x_valid && (count_q == '0);

        // Training always owns the write port; a matching pending reset folds into it.
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            hist_d      = {hist_q[HIST_W-2:0], x_taken};
            tbl_we_d    = 1'b1;
            tbl_index_d = head;
            tbl_taken_d = x_taken;
            if (rst_pend_q && (rst_idx_q == head)) begin
                tbl_op_d   = OP_BOTH;
                rst_pend_d = 1'b0;
            end else begin
                tbl_op_d   = OP_TRAIN;
            end
        end else if (rst_pend_q) begin
            tbl_we_d    = 1'b1;
            tbl_op_d    = OP_RST;
            tbl_index_d = rst_idx_q;
            rst_pend_d  = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (d_new) begin
                rst_pend_d = 1'b1;
                rst_idx_d  = d_index;
            end
        end

        // A mispredict discards every younger in-flight branch.
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rst_pend_q  <= 1'b0;
            rst_idx_q   <= '0;
            hist_q      <= '0;
            tbl_we_q    <= 1'b0;
            tbl_op_q    <= OP_IDLE;
            tbl_index_q <= '0;
            tbl_taken_q <= 1'b0;
            x_err_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= d_index;
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rst_pend_q  <= rst_pend_d;
            rst_idx_q   <= rst_idx_d;
            hist_q      <= hist_d;
            tbl_we_q    <= tbl_we_d;
            tbl_op_q    <= tbl_op_d;
            tbl_index_q <= tbl_index_d;
            tbl_taken_q <= tbl_taken_d;
            x_err_q     <= x_err_d;
        end
    end

    assign tbl_we    = tbl_we_q;
    assign tbl_op    = tbl_op_q;
    assign tbl_index = tbl_index_q;
    assign tbl_taken = tbl_taken_q;
    assign history   = hist_q;
    assign count     = count_q;
    assign x_err     = x_err_q;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Bench for branch_update_ctrl: hand-computed per-cycle vectors, a training scoreboard
// for the full/wrap traffic, and an asynchronous reset sequence.
module tb_branch_update_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid, d_new, d_ready;
    logic [7:0] d_index;
    logic       x_valid, x_taken, x_mispredict;
    logic       tbl_we, tbl_taken, x_err;
    logic [1:0] tbl_op;
    logic [7:0] tbl_index;
    logic [3:0] history;
    logic [2:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    branch_update_ctrl #(.DEPTH(4), .IDX_W(8), .HIST_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_index(d_index), .d_new(d_new), .d_ready(d_ready),
        .x_valid(x_valid), .x_taken(x_taken), .x_mispredict(x_mispredict),
        .tbl_we(tbl_we), .tbl_op(tbl_op), .tbl_index(tbl_index), .tbl_taken(tbl_taken),
        .history(history), .count(count), .x_err(x_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [7:0] di;
        logic       dn;
        logic       xv;
        logic       xt;
        logic       xm;
        logic       we;
        logic [1:0] op;
        logic [7:0] idx;
        logic       tk;
        logic [3:0] hist;
        logic [2:0] cnt;
        logic       err;
        logic       rdy;
    } vec_t;

    typedef struct {
        logic [7:0] idx;
        logic       tk;
    } wr_t;

    vec_t       vecs [22];
    logic [7:0] inflight [$];
    wr_t        exp_wr [$];
    logic [3:0] hist_m;

    function automatic vec_t mk(input logic dv, input logic [7:0] di, input logic dn,
                                input logic xv, input logic xt, input logic xm,
                                input logic we, input logic [1:0] op, input logic [7:0] idx,
                                input logic tk, input logic [3:0] hist, input logic [2:0] cnt,
                                input logic err, input logic rdy);
        vec_t v;
        v.dv = dv; v.di = di; v.dn = dn; v.xv = xv; v.xt = xt; v.xm = xm;
        v.we = we; v.op = op; v.idx = idx; v.tk = tk; v.hist = hist; v.cnt = cnt;
        v.err = err; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic drive(input logic dv, input logic [7:0] di, input logic dn,
                         input logic xv, input logic xt, input logic xm);
        d_valid = dv; d_index = di; d_new = dn;
        x_valid = xv; x_taken = xt; x_mispredict = xm;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_cycle(input logic dv, input logic [7:0] di, input logic xv, input logic xt);
        wr_t  w;
        logic accept;
        accept = dv && (inflight.size() < 4);
        if (xv && inflight.size() > 0) begin
            w.idx = inflight.pop_front();
            w.tk  = xt;
            exp_wr.push_back(w);
            hist_m = {hist_m[2:0], xt};
        end
        if (accept) inflight.push_back(di);
        drive(dv, di, 1'b0, xv, xt, 1'b0);
        chk("sb.we", 32'(tbl_we), 32'(exp_wr.size() > 0));
        if (tbl_we && exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("sb.idx", 32'(tbl_index), 32'(w.idx));
            chk("sb.taken", 32'(tbl_taken), 32'(w.tk));
            chk("sb.op", 32'(tbl_op), 32'(2'b10));
        end
        chk("sb.count", 32'(count), 32'(inflight.size()));
        chk("sb.hist", 32'(history), 32'(hist_m));
        chk("sb.ready", 32'(d_ready), 32'(inflight.size() < 4));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".we"},    32'(tbl_we),    32'(0));
        chk({tag, ".op"},    32'(tbl_op),    32'(0));
        chk({tag, ".idx"},   32'(tbl_index), 32'(0));
        chk({tag, ".taken"}, 32'(tbl_taken), 32'(0));
        chk({tag, ".hist"},  32'(history),   32'(0));
        chk({tag, ".count"}, 32'(count),     32'(0));
        chk({tag, ".err"},   32'(x_err),     32'(0));
        chk({tag, ".ready"}, 32'(d_ready),   32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                dv di    dn xv xt xm  we op     idx   tk hist   cnt  err rdy
        vecs[0]  = mk(1, 8'h08, 1, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h0, 3'd1, 0, 0);
        vecs[1]  = mk(1, 8'h10, 0, 0, 0, 0,  1, 2'b01, 8'h08, 0, 4'h0, 3'd1, 0, 1);
        vecs[2]  = mk(1, 8'h10, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h0, 3'd2, 0, 1);
        vecs[3]  = mk(0, 8'h00, 0, 1, 1, 0,  1, 2'b10, 8'h08, 1, 4'h1, 3'd1, 0, 1);
        vecs[4]  = mk(0, 8'h00, 0, 1, 0, 0,  1, 2'b10, 8'h10, 0, 4'h2, 3'd0, 0, 1);
        vecs[5]  = mk(1, 8'h20, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h2, 3'd1, 0, 1);
        vecs[6]  = mk(0, 8'h00, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h2, 3'd1, 0, 1);
        vecs[7]  = mk(1, 8'h18, 1, 1, 1, 0,  1, 2'b10, 8'h20, 1, 4'h5, 3'd1, 0, 0);
        vecs[8]  = mk(0, 8'h00, 0, 0, 0, 0,  1, 2'b01, 8'h18, 0, 4'h5, 3'd1, 0, 1);
        vecs[9]  = mk(1, 8'h18, 1, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h5, 3'd2, 0, 0);
        vecs[10] = mk(0, 8'h00, 0, 1, 0, 0,  1, 2'b11, 8'h18, 0, 4'hA, 3'd1, 0, 1);
        vecs[11] = mk(0, 8'h00, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'hA, 3'd1, 0, 1);
        vecs[12] = mk(0, 8'h00, 0, 1, 1, 0,  1, 2'b10, 8'h18, 1, 4'h5, 3'd0, 0, 1);
        vecs[13] = mk(1, 8'h01, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h5, 3'd1, 0, 1);
        vecs[14] = mk(1, 8'h02, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h5, 3'd2, 0, 1);
        vecs[15] = mk(1, 8'h03, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'h5, 3'd3, 0, 1);
        vecs[16] = mk(1, 8'h04, 1, 1, 1, 1,  1, 2'b10, 8'h01, 1, 4'hB, 3'd0, 0, 1);
        vecs[17] = mk(0, 8'h00, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'hB, 3'd0, 0, 1);
        vecs[18] = mk(1, 8'h30, 0, 1, 1, 0,  0, 2'b00, 8'h00, 0, 4'hB, 3'd1, 1, 1);
        vecs[19] = mk(0, 8'h00, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'hB, 3'd1, 0, 1);
        vecs[20] = mk(0, 8'h00, 0, 0, 0, 0,  0, 2'b00, 8'h00, 0, 4'hB, 3'd1, 0, 1);
        vecs[21] = mk(0, 8'h00, 0, 1, 0, 0,  1, 2'b10, 8'h30, 0, 4'h6, 3'd0, 0, 1);

        rst_n = 1'b0;
        d_valid = 1'b0; d_index = '0; d_new = 1'b0;
        x_valid = 1'b0; x_taken = 1'b0; x_mispredict = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel.ready", 32'(d_ready), 32'(1));
        chk("rst_rel.count", 32'(count), 32'(0));

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].dv, vecs[i].di, vecs[i].dn, vecs[i].xv, vecs[i].xt, vecs[i].xm);
            chk($sformatf("v%0d.we", i),    32'(tbl_we),  32'(vecs[i].we));
            chk($sformatf("v%0d.op", i),    32'(tbl_op),  32'(vecs[i].op));
            chk($sformatf("v%0d.hist", i),  32'(history), 32'(vecs[i].hist));
            chk($sformatf("v%0d.count", i), 32'(count),   32'(vecs[i].cnt));
            chk($sformatf("v%0d.err", i),   32'(x_err),   32'(vecs[i].err));
            chk($sformatf("v%0d.ready", i), 32'(d_ready), 32'(vecs[i].rdy));
            if (vecs[i].we) begin
                chk($sformatf("v%0d.idx", i), 32'(tbl_index), 32'(vecs[i].idx));
            end
            if (vecs[i].op[1]) begin
                chk($sformatf("v%0d.taken", i), 32'(tbl_taken), 32'(vecs[i].tk));
            end
        end

        // Fill, overflow attempt, full-queue pop, then steady pop+push across pointer wrap.
        hist_m = 4'h6;
        for (int i = 0; i < 4; i++) sb_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        sb_cycle(1'b1, 8'h44, 1'b0, 1'b0);
        sb_cycle(1'b1, 8'h45, 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 9; i++) begin
            sb_cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) sb_cycle(1'b0, 8'h00, 1'b1, 1'($urandom_range(0, 1)));
        chk("sb.drained", 32'(exp_wr.size()), 32'(0));

        // Asynchronous reset in the middle of a training write with a live history.
        drive(1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre.rst_op", 32'(tbl_op), 32'(2'b01));
        drive(1'b1, 8'h51, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre.train_we", 32'(tbl_we), 32'(1));
        chk("pre.train_idx", 32'(tbl_index), 32'(8'h50));
        x_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        #1;
        chk_reset_outputs("async_hold");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post.ready", 32'(d_ready), 32'(1));
        chk("post.we", 32'(tbl_we), 32'(0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post.no_reset_issue", 32'(tbl_we), 32'(0));
        chk("post.count", 32'(count), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
